sid_dac_rx: RTL and testbench
=============================

// Module: sid_dac_rx
// PURPOSE
//  Receive end of the SID dual serial-DAC link (DAC_clk/DAC_dat_1/DAC_dat_2/DAC_leb/DAC_csb).
//  Oversamples the five link lines in the system clock domain and deserialises the two data lines.
//  Recovers both 12-bit channel samples and presents them with a one-cycle valid strobe.
//  Sits in the test/loopback path and in downstream audio macros that consume SID output.
// PARAMETERS
//  SYNC_STAGES  2        flops per input synchroniser (>=2)
//  FRAME_BITS   16       DAC_clk rising edges per valid frame (4 config + 12 data), MSB first
//  CFG_EXPECT   4'b0011  required config nibble (frame bits 15:12), used only with DAC_RX_CFG_CHECK_EN
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   reset, asynchronous assert, active low
//  dac_clk_in    in   1   link serial clock (async to clk)
//  dac_dat_1_in  in   1   channel 1 serial data
//  dac_dat_2_in  in   1   channel 2 serial data
//  dac_leb_in    in   1   latch enable, active low
//  dac_csb_in    in   1   chip select, active low, frames a word
//  sample_1      out  12  last latched channel 1 sample
//  sample_2      out  12  last latched channel 2 sample
//  sample_valid  out  1   1-cycle pulse: sample_1/2 just updated
//  frame_err     out  1   1-cycle pulse: frame discarded (bit count or config)
//  overrun       out  1   1-cycle pulse: pending frame overwritten before latch
// BEHAVIOUR
//  - Reset: all outputs 0, shift regs/pending 0, bit count 0, pend_vld 0, FSM IDLE.
//  - Each input passes SYNC_STAGES flops; edges detected vs. one extra registered copy.
//    Link half-periods must be >= SYNC_STAGES+1 clk cycles; shorter pulses undefined.
//  - FSM IDLE: on csb falling edge -> SHIFT, cnt<=0. csb already low after reset: stay IDLE
//    until a full high-then-low edge (partial frame never accepted).
//  - FSM SHIFT: each DAC_clk rising edge shifts dat_1/dat_2 into 16-bit regs (LSB in), cnt+1,
//    cnt saturates at FRAME_BITS+1. On csb rising edge -> IDLE and evaluate frame:
//    cnt==FRAME_BITS (and cfg ok) -> pending<=data[11:0] both channels, pend_vld<=1,
//      overrun pulses if pend_vld was 1 and not consumed in this cycle;
//    otherwise frame_err pulses, pending untouched.
//  - Same-cycle DAC_clk rise and csb rise: shift first, then evaluate (bit counts).
//  - leb falling edge with pend_vld=1: sample_1/2 <= pending, sample_valid pulse, pend_vld<=0.
//    With pend_vld=0: ignored, outputs hold, no pulse. leb edge during SHIFT acts on pending.
//  - leb fall and frame commit in same cycle: previous pending latched to outputs, new frame
//    becomes pending (pend_vld stays 1), no overrun.
//  - Latency: leb fall at pin -> sample_valid high SYNC_STAGES+2 clk edges later.
//  - Reset mid-frame: async clear of everything; frame in flight lost silently.
// CONFIGURATION
//  DAC_RX_CFG_CHECK_EN defined: frame bits 15:12 of BOTH channels must equal CFG_EXPECT,
//    else frame_err pulse and frame discarded (checked together with bit count).
//  Not defined: config nibble ignored; only bit count decides acceptance.
// TESTING
//  1 frame ch1=0xABC ch2=0x123 cfg 0x3, 16 clks, csb high, leb pulse -> sample_1=0xABC,
//    sample_2=0x123, one sample_valid pulse, no err.
//  2 frame with 15 clks then leb -> frame_err pulse, no sample_valid, samples hold prior.
//  3 frames 0x111 then 0x222 without leb, then leb -> overrun pulse on 2nd commit,
//    sample_1=0x222.
//  4 cfg nibble 0x7 ch1=0x555: with CFG_CHECK_EN -> frame_err; without -> sample_1=0x555.
//  5 rst_n low after 8 clks, release with csb low, finish frame, leb -> no sample_valid;
//    next full frame accepted normally.
//  6 leb fall in same clk as csb rise of frame B with A pending -> outputs=A, valid pulse,
//    next leb -> outputs=B.

Source files
------------

// File: rtl/sid_dac_rx.sv
// sid_dac_rx: receive end of the SID dual serial-DAC link.
// Oversamples DAC_clk/dat_1/dat_2/leb/csb in the clk domain, deserialises
// both data lines and presents the 12-bit channel samples on a leb falling
// edge, with a one-cycle sample_valid strobe.
// Optional build macro: DAC_RX_CFG_CHECK_EN (require config nibble == CFG_EXPECT
// on both channels for a frame to be accepted).
module sid_dac_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FRAME_BITS  = 16,
   parameter logic [3:0]  CFG_EXPECT  = 4'b0011
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dac_clk_in,
   input  logic        dac_dat_1_in,
   input  logic        dac_dat_2_in,
   input  logic        dac_leb_in,
   input  logic        dac_csb_in,
   output logic [11:0] sample_1,
   output logic [11:0] sample_2,
   output logic        sample_valid,
   output logic        frame_err,
   output logic        overrun
);

   localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

   // Line positions inside the packed synchroniser vectors
   localparam int unsigned L_CLK = 0;
   localparam int unsigned L_D1  = 1;
   localparam int unsigned L_D2  = 2;
   localparam int unsigned L_LEB = 3;
   localparam int unsigned L_CSB = 4;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   logic [4:0]            pins;
   logic [4:0]            sync_q [SYNC_STAGES];
   logic [4:0]            prev_q;
   logic                  clk_rise;
   logic                  csb_fall;
   logic                  csb_rise;
   logic                  leb_fall;
   logic                  dat_1_q;
   logic                  dat_2_q;

   state_t                state_q;
   logic [FRAME_BITS-1:0] shift_1_q;
   logic [FRAME_BITS-1:0] shift_2_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [11:0]           pend_1_q;
   logic [11:0]           pend_2_q;
   logic                  pend_vld_q;

   logic [FRAME_BITS-1:0] shift_1_n;
   logic [FRAME_BITS-1:0] shift_2_n;
   logic [CNT_W-1:0]      cnt_n;
   logic                  cfg_ok;
   logic                  frame_ok;
   logic                  commit;
   logic                  latch;

   assign pins = {dac_csb_in, dac_leb_in, dac_dat_2_in, dac_dat_1_in, dac_clk_in};

   // Synchronise all link lines, keep one delayed copy and register edge pulses
   // (data is registered alongside so it stays aligned with clk_rise)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q   <= '0;
         clk_rise <= 1'b0;
         csb_fall <= 1'b0;
         csb_rise <= 1'b0;
         leb_fall <= 1'b0;
         dat_1_q  <= 1'b0;
         dat_2_q  <= 1'b0;
      end else begin
         sync_q[0] <= pins;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q   <= sync_q[SYNC_STAGES-1];
         clk_rise <=  sync_q[SYNC_STAGES-1][L_CLK] & ~prev_q[L_CLK];
         csb_fall <= ~sync_q[SYNC_STAGES-1][L_CSB] &  prev_q[L_CSB];
         csb_rise <=  sync_q[SYNC_STAGES-1][L_CSB] & ~prev_q[L_CSB];
         leb_fall <= ~sync_q[SYNC_STAGES-1][L_LEB] &  prev_q[L_LEB];
         dat_1_q  <= sync_q[SYNC_STAGES-1][L_D1];
         dat_2_q  <= sync_q[SYNC_STAGES-1][L_D2];
      end
   end

   // Post-shift view of the frame so a same-cycle clk/csb rise counts the last bit
   always_comb begin
      shift_1_n = shift_1_q;
      shift_2_n = shift_2_q;
      cnt_n     = cnt_q;
      if (clk_rise) begin
         shift_1_n = FRAME_BITS'({shift_1_q, dat_1_q});
         shift_2_n = FRAME_BITS'({shift_2_q, dat_2_q});
         if (cnt_q != CNT_SAT) begin
            cnt_n = cnt_q + 1'b1;
         end
      end
`ifdef DAC_RX_CFG_CHECK_EN
      cfg_ok = (shift_1_n[FRAME_BITS-1 -: 4] == CFG_EXPECT) &&
               (shift_2_n[FRAME_BITS-1 -: 4] == CFG_EXPECT);
`else
      cfg_ok = 1'b1;
`endif
      frame_ok = (cnt_n == CNT_FULL) && cfg_ok;
      commit   = (state_q == ST_SHIFT) && csb_rise && frame_ok;
      latch    = leb_fall && pend_vld_q;
   end

   // Frame FSM, pending buffer and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         shift_1_q    <= '0;
         shift_2_q    <= '0;
         cnt_q        <= '0;
         pend_1_q     <= '0;
         pend_2_q     <= '0;
         pend_vld_q   <= 1'b0;
         sample_1     <= '0;
         sample_2     <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (csb_fall) begin
                  state_q <= ST_SHIFT;
                  cnt_q   <= '0;
               end
            end
            ST_SHIFT: begin
               shift_1_q <= shift_1_n;
               shift_2_q <= shift_2_n;
               cnt_q     <= cnt_n;
               if (csb_rise) begin
                  state_q <= ST_IDLE;
                  if (frame_ok) begin
                     pend_1_q <= shift_1_n[11:0];
                     pend_2_q <= shift_2_n[11:0];
                     overrun  <= pend_vld_q && !leb_fall;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         // A latch in the commit cycle still takes the old pending value
         if (latch) begin
            sample_1     <= pend_1_q;
            sample_2     <= pend_2_q;
            sample_valid <= 1'b1;
         end

         if (commit) begin
            pend_vld_q <= 1'b1;
         end else if (latch) begin
            pend_vld_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sid_dac_rx.sv
// tb_sid_dac_rx: scoreboard bench for sid_dac_rx. Stimulus tasks push the
// expected output event when they issue the edge that causes it; a monitor
// pops and compares whenever the DUT raises any output strobe.
module tb_sid_dac_rx;

   logic        clk;
   logic        rst_n;
   logic        dac_clk_in;
   logic        dac_dat_1_in;
   logic        dac_dat_2_in;
   logic        dac_leb_in;
   logic        dac_csb_in;
   logic [11:0] sample_1;
   logic [11:0] sample_2;
   logic        sample_valid;
   logic        frame_err;
   logic        overrun;

   typedef struct {
      logic        v;
      logic        e;
      logic        o;
      logic [11:0] s1;
      logic [11:0] s2;
   } ev_t;

   ev_t         exp_q[$];
   int          vectors;
   int          miscompares;
   logic [11:0] m1;
   logic [11:0] m2;

   sid_dac_rx #(
      .SYNC_STAGES(2),
      .FRAME_BITS (16),
      .CFG_EXPECT (4'b0011)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dac_clk_in   (dac_clk_in),
      .dac_dat_1_in (dac_dat_1_in),
      .dac_dat_2_in (dac_dat_2_in),
      .dac_leb_in   (dac_leb_in),
      .dac_csb_in   (dac_csb_in),
      .sample_1     (sample_1),
      .sample_2     (sample_2),
      .sample_valid (sample_valid),
      .frame_err    (frame_err),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every output strobe must match the head of the expectation queue
   always @(negedge clk) begin
      if (rst_n && (sample_valid || frame_err || overrun)) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got v=%0b e=%0b o=%0b s1=%h s2=%h, required none",
                     sample_valid, frame_err, overrun, sample_1, sample_2);
         end else begin
            ev_t x;
            x = exp_q.pop_front();
            if (sample_valid !== x.v || frame_err !== x.e || overrun !== x.o ||
                sample_1 !== x.s1 || sample_2 !== x.s2) begin
               miscompares++;
               $display("FAIL event: got v=%0b e=%0b o=%0b s1=%h s2=%h, required v=%0b e=%0b o=%0b s1=%h s2=%h",
                        sample_valid, frame_err, overrun, sample_1, sample_2,
                        x.v, x.e, x.o, x.s1, x.s2);
            end
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic v, input logic e, input logic o);
      ev_t x;
      x.v  = v;
      x.e  = e;
      x.o  = o;
      x.s1 = m1;
      x.s2 = m2;
      exp_q.push_back(x);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic start_frame();
      dac_csb_in = 1'b0;
      wait_clks(4);
   endtask

   // Shift bits [15-first .. 15-first-n+1] of both words, MSB first
   task automatic send_bits(input logic [15:0] w1, input logic [15:0] w2,
                            input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         dac_dat_1_in = w1[15-i];
         dac_dat_2_in = w2[15-i];
         wait_clks(4);
         dac_clk_in = 1'b1;
         wait_clks(4);
         dac_clk_in = 1'b0;
      end
   endtask

   task automatic end_frame();
      dac_csb_in = 1'b1;
      wait_clks(4);
   endtask

   task automatic leb_pulse();
      dac_leb_in = 1'b0;
      wait_clks(4);
      dac_leb_in = 1'b1;
      wait_clks(4);
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      m1           = '0;
      m2           = '0;
      rst_n        = 1'b0;
      dac_clk_in   = 1'b0;
      dac_dat_1_in = 1'b0;
      dac_dat_2_in = 1'b0;
      dac_leb_in   = 1'b1;
      dac_csb_in   = 1'b1;
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(6);

      // Reset state
      check("reset_sample_1", 32'(sample_1), 32'h0);
      check("reset_sample_2", 32'(sample_2), 32'h0);
      check("reset_strobes", 32'({sample_valid, frame_err, overrun}), 32'h0);

      // 1: good frame, latch, with leb-to-valid latency check
      start_frame();
      send_bits(16'h3ABC, 16'h3123, 0, 16);
      end_frame();
      m1 = 12'hABC;
      m2 = 12'h123;
      push(1'b1, 1'b0, 1'b0);
      dac_leb_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("latency_early", 32'(sample_valid), 32'h0);
      @(posedge clk);
      #1 check("latency_valid", 32'(sample_valid), 32'h1);
      wait_clks(3);
      dac_leb_in = 1'b1;
      wait_clks(4);

      // 2: short frame (15 clocks) -> error, leb ignored
      start_frame();
      send_bits(16'h3DEF, 16'h3456, 0, 15);
      push(1'b0, 1'b1, 1'b0);
      end_frame();
      leb_pulse();
      check("short_hold_1", 32'(sample_1), 32'hABC);

      // 3: two frames without leb -> overrun on the second commit
      start_frame();
      send_bits(16'h3111, 16'h3999, 0, 16);
      end_frame();
      start_frame();
      send_bits(16'h3222, 16'h3888, 0, 16);
      push(1'b0, 1'b0, 1'b1);
      end_frame();
      m1 = 12'h222;
      m2 = 12'h888;
      push(1'b1, 1'b0, 1'b0);
      leb_pulse();

      // 4: config nibble 0x7
      start_frame();
      send_bits(16'h7555, 16'h7AAA, 0, 16);
`ifdef DAC_RX_CFG_CHECK_EN
      push(1'b0, 1'b1, 1'b0);
      end_frame();
      leb_pulse();
`else
      end_frame();
      m1 = 12'h555;
      m2 = 12'hAAA;
      push(1'b1, 1'b0, 1'b0);
      leb_pulse();
`endif

      // 5: reset mid-frame, release with csb low, finish frame -> nothing
      start_frame();
      send_bits(16'h3F0F, 16'h30F0, 0, 8);
      rst_n = 1'b0;
      m1 = '0;
      m2 = '0;
      wait_clks(3);
      check("midreset_sample_1", 32'(sample_1), 32'h0);
      check("midreset_sample_2", 32'(sample_2), 32'h0);
      rst_n = 1'b1;
      wait_clks(2);
      send_bits(16'h3F0F, 16'h30F0, 8, 8);
      end_frame();
      leb_pulse();
      check("partial_hold_1", 32'(sample_1), 32'h0);
      start_frame();
      send_bits(16'h3456, 16'h3789, 0, 16);
      end_frame();
      m1 = 12'h456;
      m2 = 12'h789;
      push(1'b1, 1'b0, 1'b0);
      leb_pulse();

      // 6: leb fall in the same cycle as frame B commit while A is pending
      start_frame();
      send_bits(16'h3A5A, 16'h35A5, 0, 16);
      end_frame();
      start_frame();
      send_bits(16'h3B6B, 16'h36B6, 0, 16);
      m1 = 12'hA5A;
      m2 = 12'h5A5;
      push(1'b1, 1'b0, 1'b0);
      dac_csb_in = 1'b1;
      dac_leb_in = 1'b0;
      wait_clks(4);
      dac_leb_in = 1'b1;
      wait_clks(4);
      m1 = 12'hB6B;
      m2 = 12'h6B6;
      push(1'b1, 1'b0, 1'b0);
      leb_pulse();
      check("final_sample_1", 32'(sample_1), 32'hB6B);
      check("final_sample_2", 32'(sample_2), 32'h6B6);

      // Drain: every expected event must have been seen within a bounded time
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
         wait_clks(1);
      end
      while (exp_q.size() != 0) begin
         ev_t x;
         x = exp_q.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL missing_event: got none, required v=%0b e=%0b o=%0b s1=%h s2=%h",
                  x.v, x.e, x.o, x.s1, x.s2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
